// File: rtl/reg_file_pkg.sv
// Shared integer-register constants for the RV32IM decode, hazard and write-back stages.
package reg_file_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// RV32 integer register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero, synchronous active-high reset clearing every entry.
module reg_file #(
   parameter int unsigned DATA_WIDTH = reg_file_pkg::XLEN,
   parameter int unsigned ADDR_WIDTH = reg_file_pkg::REG_ADDR_W,
   parameter int unsigned NUM_REGS   = reg_file_pkg::NUM_REGS
) (
   input  logic [DATA_WIDTH-1:0] WRITE_DATA,
   output logic [DATA_WIDTH-1:0] DATA1,
   output logic [DATA_WIDTH-1:0] DATA2,
   input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
   input  logic [ADDR_WIDTH-1:0] DATA1_ADDRESS,
   input  logic [ADDR_WIDTH-1:0] DATA2_ADDRESS,
   input  logic                  WRITE_ENABLE,
   input  logic                  CLK,
   input  logic                  RESET
);

   import reg_file_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   // Flip-flop array so reset reaches every entry
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic write_hit;

   // Writes to x0 are dropped; reset outranks a simultaneous write
   always_comb begin
      write_hit = 1'b0;
      if (WRITE_ENABLE && (WRITE_ADDRESS != ZERO_ADDR)) begin
         write_hit = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
      end else if (write_hit) begin
         regs[WRITE_ADDRESS] <= WRITE_DATA;
      end
   end

   // No write-to-read bypass: forwarding belongs to the hazard unit
   always_comb begin
      DATA1 = '0;
      DATA2 = '0;
      if (DATA1_ADDRESS != ZERO_ADDR) begin
         DATA1 = regs[DATA1_ADDRESS];
      end
      if (DATA2_ADDRESS != ZERO_ADDR) begin
         DATA2 = regs[DATA2_ADDRESS];
      end
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset sweep, write/read, x0, enable gating,
// dual-port fill, reset priority and no-bypass read timing.
module tb_reg_file;

   logic [31:0] write_data;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [4:0]  write_address;
   logic [4:0]  data1_address;
   logic [4:0]  data2_address;
   logic        write_enable;
   logic        clk;
   logic        reset;

   int checks = 0;
   int errors = 0;

   reg_file dut (
      .WRITE_DATA    (write_data),
      .DATA1         (data1),
      .DATA2         (data2),
      .WRITE_ADDRESS (write_address),
      .DATA1_ADDRESS (data1_address),
      .DATA2_ADDRESS (data2_address),
      .WRITE_ENABLE  (write_enable),
      .CLK           (clk),
      .RESET         (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one write across the next rising edge, then drop the enable 1 unit later
   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      write_address = addr;
      write_data    = data;
      write_enable  = 1'b1;
      @(posedge clk);
      #1;
      write_enable  = 1'b0;
   endtask

   function automatic logic [31:0] fill_value(input int i);
      return (i == 0) ? 32'd0 : 32'(i * 3 + 1);
   endfunction

   initial begin
      write_data    = '0;
      write_address = '0;
      data1_address = '0;
      data2_address = '0;
      write_enable  = 1'b0;
      reset         = 1'b0;

      // x0 reads zero even before any reset
      #1;
      check("x0_pre_reset_d1", data1, 32'd0);
      check("x0_pre_reset_d2", data2, 32'd0);

      // One-edge reset pulse, then sweep both ports
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         data1_address = 5'(i);
         data2_address = 5'(31 - i);
         #1;
         check("reset_sweep_d1", data1, 32'd0);
         check("reset_sweep_d2", data2, 32'd0);
      end

      // Basic write then read 3 units after the edge
      write_address = 5'd1;
      write_data    = 32'd10;
      write_enable  = 1'b1;
      @(posedge clk);
      #3;
      write_enable  = 1'b0;
      data1_address = 5'd1;
      #1;
      check("basic_write", data1, 32'd10);

      // Writes to x0 are discarded
      do_write(5'd0, 32'hDEADBEEF);
      data1_address = 5'd0;
      data2_address = 5'd0;
      #1;
      check("x0_write_d1", data1, 32'd0);
      check("x0_write_d2", data2, 32'd0);

      // Enable low leaves register 5 untouched
      write_address = 5'd5;
      write_data    = 32'd7;
      write_enable  = 1'b0;
      @(posedge clk);
      #1;
      data1_address = 5'd5;
      #1;
      check("we_gating", data1, 32'd0);

      // Fill x1..x31 with i*3+1 and read both ports crosswise
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i * 3 + 1));
      end
      for (int i = 0; i < 32; i++) begin
         data1_address = 5'(i);
         data2_address = 5'(31 - i);
         #1;
         check("fill_d1", data1, fill_value(i));
         check("fill_d2", data2, fill_value(31 - i));
      end
      data1_address = 5'd31;
      data2_address = 5'd31;
      #1;
      check("same_addr_d1", data1, 32'd94);
      check("same_addr_d2", data2, 32'd94);

      // Reset wins over a simultaneous write
      reset         = 1'b1;
      write_enable  = 1'b1;
      write_address = 5'd4;
      write_data    = 32'd99;
      @(posedge clk);
      #1;
      reset         = 1'b0;
      write_enable  = 1'b0;
      data1_address = 5'd4;
      data2_address = 5'd10;
      #1;
      check("reset_prio_r4", data1, 32'd0);
      check("reset_prio_r10", data2, 32'd0);

      // Reset raised between edges has no effect until the edge
      do_write(5'd6, 32'd20);
      data1_address = 5'd6;
      reset = 1'b1;
      #1;
      check("reset_mid_cycle", data1, 32'd20);
      reset = 1'b0;
      #1;

      // No bypass: old value before the write edge, new value after
      write_address = 5'd6;
      write_data    = 32'd55;
      write_enable  = 1'b1;
      #1;
      check("no_bypass_before", data1, 32'd20);
      @(posedge clk);
      #1;
      write_enable  = 1'b0;
      check("no_bypass_after", data1, 32'd55);

      // Back-to-back writes to one register: each visible for one cycle
      data1_address = 5'd7;
      write_address = 5'd7;
      write_data    = 32'd1;
      write_enable  = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_first", data1, 32'd1);
      write_data    = 32'd2;
      @(posedge clk);
      #1;
      write_enable  = 1'b0;
      check("b2b_last", data1, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_reg_file
